// File: rtl/prod_accum_pkg.sv
// ============================================================================
// Module      : prod_accum_pkg
// Description : Shared ALU types and constants for the product accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package prod_accum_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_OUT   = 2'd2
    } state_t;

    typedef logic signed [63:0] prod_t;

    localparam prod_t SAT_MAX = 64'sh7FFF_FFFF_FFFF_FFFF;
    localparam prod_t SAT_MIN = 64'sh8000_0000_0000_0000;

endpackage : prod_accum_pkg

`default_nettype wire

// File: rtl/prod_accum_sat_add64.sv
// ============================================================================
// Module      : sat_add64
// Description : 64-bit signed add with clamp to the signed range and flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_add64
    import prod_accum_pkg::*;
(
    input  prod_t i_a,
    input  prod_t i_b,
    output prod_t o_sum,
    output logic  o_ovf
);

    logic signed [64:0] w_sum65;
    logic               w_pos_ovf;
    logic               w_neg_ovf;

    assign w_sum65 = {i_a[63], i_a} + {i_b[63], i_b};

    // Bits 64 and 63 disagree only when the true sum left the 64-bit range.
    assign w_pos_ovf = ~w_sum65[64] &  w_sum65[63];
    assign w_neg_ovf =  w_sum65[64] & ~w_sum65[63];

    assign o_sum = w_pos_ovf ? SAT_MAX :
                   w_neg_ovf ? SAT_MIN : prod_t'(w_sum65[63:0]);
    assign o_ovf = w_pos_ovf | w_neg_ovf;

endmodule : sat_add64

`default_nettype wire

// File: rtl/prod_accum.sv
// ============================================================================
// Module      : prod_accum
// Description : Saturating group accumulator for signed 64-bit products.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prod_accum
    import prod_accum_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [63:0]      in_data,
    input  logic             in_last,
    output logic             in_ready,
    input  logic             clear,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [63:0]      res_data,
    output logic             res_ovf,
    output logic [CNT_W-1:0] res_count
);

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             r_state;
    state_t             w_state_nxt;

    prod_t              r_acc;
    logic               r_ovf;
    logic [CNT_W-1:0]   r_cnt;

    prod_t              r_res_data;
    logic               r_res_ovf;
    logic [CNT_W-1:0]   r_res_count;

    prod_t              w_sum;
    logic               w_add_ovf;
    logic               w_grp_ovf;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_beat;
    logic               w_xfer;
    logic               w_res_valid;

    sat_add64 u_sat_add64 (
        .i_a   (r_acc),
        .i_b   (prod_t'(in_data)),
        .o_sum (w_sum),
        .o_ovf (w_add_ovf)
    );

    assign w_res_valid = (r_state == ST_OUT);
    assign in_ready    = ~clear & (~w_res_valid | res_ready);
    assign w_beat      = in_valid & in_ready;
    assign w_xfer      = w_res_valid & res_ready;
    assign w_grp_ovf   = r_ovf | w_add_ovf;
    assign w_cnt_inc   = (&r_cnt) ? r_cnt : r_cnt + c_cnt_one;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_beat) begin
                    w_state_nxt = in_last ? ST_OUT : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (clear) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_beat && in_last) begin
                    w_state_nxt = ST_OUT;
                end
            end
            ST_OUT: begin
                // A beat in OUT implies res_ready, so the held result is leaving.
                if (w_beat && in_last) begin
                    w_state_nxt = ST_OUT;
                end else if (w_xfer) begin
                    if (w_beat || (!clear && (r_cnt != '0))) begin
                        w_state_nxt = ST_ACCUM;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Running group state; a last beat hands its totals to the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
            r_cnt <= '0;
        end else if (clear || (w_beat && in_last)) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
            r_cnt <= '0;
        end else if (w_beat) begin
            r_acc <= w_sum;
            r_ovf <= w_grp_ovf;
            r_cnt <= w_cnt_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_data  <= '0;
            r_res_ovf   <= 1'b0;
            r_res_count <= '0;
        end else if (w_beat && in_last) begin
            r_res_data  <= w_sum;
            r_res_ovf   <= w_grp_ovf;
            r_res_count <= w_cnt_inc;
        end
    end

    assign res_valid = w_res_valid;
    assign res_data  = r_res_data;
    assign res_ovf   = r_res_ovf;
    assign res_count = r_res_count;

endmodule : prod_accum

`default_nettype wire

// File: tb/tb_prod_accum.sv
// ============================================================================
// Module      : tb_prod_accum
// Description : Directed self-checking bench for prod_accum.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prod_accum;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic [63:0]      in_data;
    logic             in_last;
    logic             in_ready;
    logic             clear;
    logic             res_valid;
    logic             res_ready;
    logic [63:0]      res_data;
    logic             res_ovf;
    logic [CNT_W-1:0] res_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    prod_accum #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .clear     (clear),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_ovf   (res_ovf),
        .res_count (res_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [63:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        clear     = 1'b0;
        res_ready = 1'b1;
        tick();
        tick();
        check("rst_valid", 64'(res_valid), 64'd0);
        check("rst_data",  res_data, 64'd0);
        check("rst_ovf",   64'(res_ovf), 64'd0);
        check("rst_count", 64'(res_count), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        tick();

        // Basic group: 5 + -3 + 10
        beat(64'd5, 1'b0);
        beat(-64'sd3, 1'b0);
        beat(64'd10, 1'b1);
        check("g1_valid", 64'(res_valid), 64'd1);
        check("g1_data",  res_data, 64'd12);
        check("g1_count", 64'(res_count), 64'd3);
        check("g1_ovf",   64'(res_ovf), 64'd0);
        tick();
        check("g1_drain", 64'(res_valid), 64'd0);

        // Positive clamp, then a clean group overlapping the result transfer
        beat(64'h7FFF_FFFF_FFFF_FFF0, 1'b0);
        beat(64'h100, 1'b1);
        check("pos_data", res_data, 64'h7FFF_FFFF_FFFF_FFFF);
        check("pos_ovf",  64'(res_ovf), 64'd1);
        check("pos_count", 64'(res_count), 64'd2);
        beat(64'd1, 1'b0);
        check("ovl_valid", 64'(res_valid), 64'd0);
        beat(64'd2, 1'b1);
        check("g2_data", res_data, 64'd3);
        check("g2_ovf",  64'(res_ovf), 64'd0);
        tick();

        // Negative clamp
        beat(64'h8000_0000_0000_0010, 1'b0);
        beat(64'hFFFF_FFFF_FFFF_FF00, 1'b1);
        check("neg_data", res_data, 64'h8000_0000_0000_0000);
        check("neg_ovf",  64'(res_ovf), 64'd1);
        tick();

        // Backpressure: held result, blocked input, clear leaves result alone
        res_ready = 1'b0;
        beat(64'd20, 1'b1);
        in_valid = 1'b1;
        in_data  = 64'd7;
        in_last  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("bp_ready", 64'(in_ready), 64'd0);
            check("bp_data",  res_data, 64'd20);
            check("bp_valid", 64'(res_valid), 64'd1);
            tick();
        end
        clear = 1'b1;
        #1;
        check("bp_clr_ready", 64'(in_ready), 64'd0);
        tick();
        clear = 1'b0;
        check("bp_clr_data",  res_data, 64'd20);
        check("bp_clr_valid", 64'(res_valid), 64'd1);
        res_ready = 1'b1;
        #1;
        check("bp_rel_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("bp_new_valid", 64'(res_valid), 64'd1);
        check("bp_new_data",  res_data, 64'd7);
        check("bp_new_count", 64'(res_count), 64'd1);
        tick();
        check("bp_drain", 64'(res_valid), 64'd0);

        // Clear discards a partial group
        beat(64'd9, 1'b0);
        beat(64'd9, 1'b0);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 64'd100;
        in_last  = 1'b1;
        #1;
        check("clr_ready", 64'(in_ready), 64'd0);
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("clr_valid", 64'(res_valid), 64'd0);
        beat(64'd4, 1'b1);
        check("clr_data",  res_data, 64'd4);
        check("clr_count", 64'(res_count), 64'd1);
        tick();

        // Reset mid-group and with a held result
        beat(64'd9, 1'b0);
        rst_n = 1'b0;
        #1;
        check("rm_valid", 64'(res_valid), 64'd0);
        tick();
        rst_n     = 1'b1;
        res_ready = 1'b0;
        beat(64'd5, 1'b1);
        check("rv_pre", 64'(res_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rv_valid", 64'(res_valid), 64'd0);
        check("rv_data",  res_data, 64'd0);
        check("rv_count", 64'(res_count), 64'd0);
        check("rv_ovf",   64'(res_ovf), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rv_post", 64'(res_valid), 64'd0);
        res_ready = 1'b1;
        beat(64'hFFFF_FFFF_FFFF_FFFA, 1'b1);
        check("post_data",  res_data, 64'hFFFF_FFFF_FFFF_FFFA);
        check("post_count", 64'(res_count), 64'd1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_prod_accum

`default_nettype wire
